// File: rtl/dvi_in_irq_if.sv
// Register-file side bundle for the DVI input interrupt controller:
// control strobes/masks in, latched status and counters out.
interface dvi_in_irq_if #(
  parameter int NumSrc   = 4,
  parameter int CntWidth = 8
);
  logic [2*NumSrc-1:0]        mode_i;
  logic [NumSrc-1:0]          enable_i;
  logic [NumSrc-1:0]          clear_i;
  logic [NumSrc-1:0]          test_set_i;
  logic [NumSrc-1:0]          cnt_clear_i;
  logic [NumSrc-1:0]          pending_o;
  logic [NumSrc-1:0]          overflow_o;
  logic [NumSrc-1:0]          irq_o;
  logic                       irq_any_o;
  logic [NumSrc*CntWidth-1:0] count_o;

  // Register file: drives controls, reads status
  modport master (
    output mode_i, enable_i, clear_i, test_set_i, cnt_clear_i,
    input  pending_o, overflow_o, irq_o, irq_any_o, count_o
  );

  // Interrupt controller: consumes controls, produces status
  modport slave (
    input  mode_i, enable_i, clear_i, test_set_i, cnt_clear_i,
    output pending_o, overflow_o, irq_o, irq_any_o, count_o
  );
endinterface

// File: rtl/dvi_in_irq_ctrl.sv
// Per-source event detector for the DVI input status lines: level/edge
// detection, pending latch, missed-event flag, saturating event counter
// and enable-gated interrupt lines.
module dvi_in_irq_ctrl #(
  parameter int NumSrc   = 4,
  parameter int CntWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] src_i,
  dvi_in_irq_if.slave       rf_if
);

  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

  logic [NumSrc-1:0]               prev_q;
  logic [NumSrc-1:0]               pending_q, pending_d;
  logic [NumSrc-1:0]               overflow_q, overflow_d;
  logic [NumSrc-1:0][CntWidth-1:0] count_q, count_d;

  logic [NumSrc-1:0] rise_s;
  logic [NumSrc-1:0] fall_s;
  logic [NumSrc-1:0] event_s;
  logic [NumSrc-1:0] edge_mode_s;
  logic [NumSrc-1:0] inc_s;

  // Edge terms and per-mode event/increment selection
  always_comb begin
    rise_s      = src_i & ~prev_q;
    fall_s      = ~src_i & prev_q;
    event_s     = '0;
    edge_mode_s = '0;
    inc_s       = '0;
    for (int k = 0; k < NumSrc; k++) begin
      case (rf_if.mode_i[2*k +: 2])
        2'b00: begin
          // Level: pending tracks the high level, but the counter only
          // advances on the rising transition.
          event_s[k]     = src_i[k];
          edge_mode_s[k] = 1'b0;
          inc_s[k]       = rise_s[k];
        end
        2'b01: begin
          event_s[k]     = rise_s[k];
          edge_mode_s[k] = 1'b1;
          inc_s[k]       = rise_s[k];
        end
        2'b10: begin
          event_s[k]     = fall_s[k];
          edge_mode_s[k] = 1'b1;
          inc_s[k]       = fall_s[k];
        end
        2'b11: begin
          event_s[k]     = rise_s[k] | fall_s[k];
          edge_mode_s[k] = 1'b1;
          inc_s[k]       = rise_s[k] | fall_s[k];
        end
        default: begin
          event_s[k]     = src_i[k];
          edge_mode_s[k] = 1'b0;
          inc_s[k]       = rise_s[k];
        end
      endcase
    end
  end

  // Pending/overflow next state: sets beat a same-cycle clear for pending,
  // while clear beats a same-cycle overflow condition
  always_comb begin
    pending_d  = (pending_q & ~rf_if.clear_i) | event_s | rf_if.test_set_i;
    overflow_d = overflow_q;
    for (int k = 0; k < NumSrc; k++) begin
      if (rf_if.clear_i[k]) begin
        overflow_d[k] = 1'b0;
      end else if (event_s[k] && pending_q[k] && edge_mode_s[k]) begin
        overflow_d[k] = 1'b1;
      end else begin
        overflow_d[k] = overflow_q[k];
      end
    end
  end

  // Saturating counter next state; a clear coinciding with an event leaves 1
  always_comb begin
    count_d = count_q;
    for (int k = 0; k < NumSrc; k++) begin
      if (rf_if.cnt_clear_i[k]) begin
        count_d[k] = inc_s[k] ? CntOne : CntZero;
      end else if (inc_s[k] && (count_q[k] != CntMax)) begin
        count_d[k] = count_q[k] + CntOne;
      end else begin
        count_d[k] = count_q[k];
      end
    end
  end

  // State registers; prev follows src during reset so a source already high
  // at release does not look like a rising edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= src_i;
      pending_q  <= '0;
      overflow_q <= '0;
      count_q    <= '0;
    end else begin
      prev_q     <= src_i;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign rf_if.pending_o  = pending_q;
  assign rf_if.overflow_o = overflow_q;
  assign rf_if.count_o    = count_q;
  assign rf_if.irq_o      = pending_q & rf_if.enable_i;
  assign rf_if.irq_any_o  = |(pending_q & rf_if.enable_i);

endmodule

// File: tb/tb_dvi_in_irq_ctrl.sv
// Directed bench for dvi_in_irq_ctrl: a 4-source/8-bit instance for the
// main behaviour and a 1-source/2-bit instance for counter saturation.
module tb_dvi_in_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] src;
  logic [0:0] src2;

  int n_checks = 0;
  int n_fail   = 0;

  dvi_in_irq_if #(.NumSrc(4), .CntWidth(8)) rf ();
  dvi_in_irq_if #(.NumSrc(1), .CntWidth(2)) rf2 ();

  dvi_in_irq_ctrl #(.NumSrc(4), .CntWidth(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .src_i (src),
    .rf_if (rf)
  );

  dvi_in_irq_ctrl #(.NumSrc(1), .CntWidth(2)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .src_i (src2),
    .rf_if (rf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then drop all one-cycle strobes
  task automatic tick();
    @(posedge clk);
    #1;
    rf.clear_i      = 4'b0000;
    rf.test_set_i   = 4'b0000;
    rf.cnt_clear_i  = 4'b0000;
    rf2.clear_i     = 1'b0;
    rf2.test_set_i  = 1'b0;
    rf2.cnt_clear_i = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    src             = 4'b0001;
    src2            = 1'b0;
    rf.mode_i       = 8'b01_01_01_01;
    rf.enable_i     = 4'b1111;
    rf.clear_i      = 4'b0000;
    rf.test_set_i   = 4'b0000;
    rf.cnt_clear_i  = 4'b0000;
    rf2.mode_i      = 2'b01;
    rf2.enable_i    = 1'b1;
    rf2.clear_i     = 1'b0;
    rf2.test_set_i  = 1'b0;
    rf2.cnt_clear_i = 1'b0;

    // Reset with source 0 held high
    tick(); tick();
    chk("rst_pending",  32'(rf.pending_o),  32'h0);
    chk("rst_overflow", 32'(rf.overflow_o), 32'h0);
    chk("rst_count",    32'(rf.count_o),    32'h0);
    chk("rst_irq",      32'(rf.irq_o),      32'h0);
    chk("rst_irq_any",  32'(rf.irq_any_o),  32'h0);
    rst = 1'b0;
    tick();
    chk("rel_high_pending", 32'(rf.pending_o), 32'h0);
    chk("rel_high_count",   32'(rf.count_o),   32'h0);
    src = 4'b0000; tick();
    chk("fall_in_rise_mode", 32'(rf.pending_o), 32'h0);
    src = 4'b0001; tick();
    chk("first_rise_pending", 32'(rf.pending_o), 32'h1);
    chk("first_rise_count",   32'(rf.count_o[7:0]), 32'd1);
    chk("first_rise_irq_any", 32'(rf.irq_any_o), 32'h1);
    rf.clear_i = 4'b0001; tick();
    chk("clear_no_event", 32'(rf.pending_o), 32'h0);
    chk("count_kept_on_clear", 32'(rf.count_o[7:0]), 32'd1);
    src = 4'b0000; tick();

    // Set beats clear on source 1
    src = 4'b0010; tick();
    chk("sbc_first_pending", 32'(rf.pending_o[1]), 32'h1);
    src = 4'b0000; tick();
    src = 4'b0010; rf.clear_i = 4'b0010; tick();
    chk("sbc_pending",  32'(rf.pending_o[1]),  32'h1);
    chk("sbc_overflow", 32'(rf.overflow_o[1]), 32'h0);
    chk("sbc_irq",      32'(rf.irq_o[1]),      32'h1);
    chk("sbc_count",    32'(rf.count_o[15:8]), 32'd2);
    src = 4'b0000; rf.clear_i = 4'b0010; tick();
    chk("sbc_cleared", 32'(rf.pending_o), 32'h0);

    // Missed events on source 2, falling mode
    rf.mode_i = 8'b01_10_01_01;
    src = 4'b0100; tick();
    chk("fall_mode_rise_ignored", 32'(rf.pending_o[2]), 32'h0);
    src = 4'b0000; tick();
    chk("fall1_count",    32'(rf.count_o[23:16]), 32'd1);
    chk("fall1_overflow", 32'(rf.overflow_o[2]),  32'h0);
    src = 4'b0100; tick();
    src = 4'b0000; tick();
    chk("fall2_overflow", 32'(rf.overflow_o[2]),  32'h1);
    src = 4'b0100; tick();
    src = 4'b0000; tick();
    chk("fall3_count",    32'(rf.count_o[23:16]), 32'd3);
    rf.clear_i = 4'b0100; tick();
    chk("missed_clr_pending",  32'(rf.pending_o[2]),  32'h0);
    chk("missed_clr_overflow", 32'(rf.overflow_o[2]), 32'h0);
    chk("missed_clr_count",    32'(rf.count_o[23:16]), 32'd3);

    // Level mode on source 3
    rf.mode_i = 8'b00_10_01_01;
    src = 4'b1000; tick();
    chk("lvl_pending_set", 32'(rf.pending_o[3]), 32'h1);
    tick();
    rf.clear_i = 4'b1000; tick();
    chk("lvl_clear_while_high", 32'(rf.pending_o[3]), 32'h1);
    tick(); tick();
    chk("lvl_pending_hold", 32'(rf.pending_o[3]),  32'h1);
    chk("lvl_no_overflow",  32'(rf.overflow_o[3]), 32'h0);
    chk("lvl_count_once",   32'(rf.count_o[31:24]), 32'd1);
    src = 4'b0000; tick();
    chk("lvl_low_no_clear", 32'(rf.pending_o[3]), 32'h1);
    rf.clear_i = 4'b1000; tick();
    chk("lvl_cleared", 32'(rf.pending_o[3]), 32'h0);
    chk("lvl_count_final", 32'(rf.count_o[31:24]), 32'd1);

    // Enable gating and test_set
    rf.enable_i = 4'b0000;
    src = 4'b0001; tick();
    chk("gate_pending", 32'(rf.pending_o), 32'h1);
    chk("gate_irq",     32'(rf.irq_o),     32'h0);
    chk("gate_irq_any", 32'(rf.irq_any_o), 32'h0);
    chk("gate_count",   32'(rf.count_o[7:0]), 32'd2);
    rf.enable_i = 4'b0001; #1;
    chk("enable_irq",     32'(rf.irq_o),     32'h1);
    chk("enable_irq_any", 32'(rf.irq_any_o), 32'h1);
    rf.test_set_i = 4'b0010; tick();
    chk("tset_pending",  32'(rf.pending_o),     32'h3);
    chk("tset_count",    32'(rf.count_o[15:8]), 32'd2);
    chk("tset_overflow", 32'(rf.overflow_o),    32'h0);
    chk("tset_irq",      32'(rf.irq_o),         32'h1);

    // Reset mid-operation
    rst = 1'b1; tick();
    chk("midrst_pending", 32'(rf.pending_o), 32'h0);
    chk("midrst_count",   32'(rf.count_o),   32'h0);
    rst = 1'b0; tick();

    // Both-edges mode on source 0
    rf.mode_i = 8'b00_10_01_11;
    src = 4'b0000; tick();
    chk("both_fall_count", 32'(rf.count_o[7:0]), 32'd1);
    rf.clear_i = 4'b0001; tick();
    chk("both_cleared", 32'(rf.pending_o), 32'h0);
    src = 4'b0001; tick();
    src = 4'b0000; tick();
    chk("pulse_count",    32'(rf.count_o[7:0]), 32'd3);
    chk("pulse_overflow", 32'(rf.overflow_o),   32'h1);
    chk("pulse_pending",  32'(rf.pending_o),    32'h1);

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      src2 = 1'b1; tick();
      src2 = 1'b0; tick();
    end
    chk("sat_count", 32'(rf2.count_o), 32'd3);
    tick();
    chk("sat_hold", 32'(rf2.count_o), 32'd3);
    src2 = 1'b1; rf2.cnt_clear_i = 1'b1; tick();
    chk("cntclr_with_inc", 32'(rf2.count_o), 32'd1);
    src2 = 1'b0; rf2.cnt_clear_i = 1'b1; tick();
    chk("cntclr_alone", 32'(rf2.count_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
